servo_ramp_scheduler: RTL and testbench
=======================================

SERVO_RAMP_SCHEDULER -- requirements
Module: servo_ramp_scheduler

Interface
REQ-001 Parameter FRAME_CYCLES, default 1000002: PWM frame period in clk cycles; frame_tick cadence.
REQ-002 Parameter STEP, default 500: maximum change of one limit per frame.
REQ-003 Parameter MIN_LIMIT, default 50000: lowest legal counter_limit.
REQ-004 Parameter MAX_LIMIT, default 100000: highest legal counter_limit.
REQ-005 Parameter CENTER, default 75000: reset value of every limit.
REQ-006 clk  input  1  single clock, all state on posedge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 cmd_valid  input  1  command present.
REQ-009 cmd_ready  output  1  scheduler can accept a command.
REQ-010 cmd_servo  input  2  target channel: 0=X, 1=Y, 2=pen, 3=illegal.
REQ-011 cmd_target  input  32  requested counter_limit.
REQ-012 limit_x, limit_y, limit_pen  output  32 each  counter_limit for the three servo PWM generators.
REQ-013 busy  output  1  ramp in progress.
REQ-014 done  output  1  one-cycle pulse on command completion.
REQ-015 cmd_err  output  1  one-cycle pulse on an illegal channel.

Function
REQ-016 Free-running frame counter counts 0..FRAME_CYCLES-1 and wraps; frame_tick is high for the single cycle at count FRAME_CYCLES-1; it runs regardless of FSM state.
REQ-017 FSM states: IDLE, RAMP, FINISH.
REQ-018 cmd_ready is 1 only in IDLE; handshake = cmd_valid && cmd_ready on a posedge.
REQ-019 On handshake, latch channel and clamped target = min(max(cmd_target, MIN_LIMIT), MAX_LIMIT), compared unsigned.
REQ-020 Handshake with cmd_servo=3: no limit changes, cmd_err=1 and done=1 in the next cycle, FSM stays in IDLE.
REQ-021 Legal handshake with clamped target equal to the current limit: go to FINISH, no frame wait.
REQ-022 Otherwise go to RAMP, busy=1 from the next cycle until return to IDLE.
REQ-023 In RAMP, on each frame_tick cycle the selected limit moves toward target by STEP; if |target-limit| <= STEP, it is set to target instead (no overshoot); all arithmetic is 32-bit unsigned with no wrap below 0.
REQ-024 The limit update is visible on the edge that samples frame_tick; limits are otherwise stable, so they change only at frame boundaries.
REQ-025 When the updated limit equals target, go to FINISH; FINISH drives done=1 for one cycle and returns to IDLE.
REQ-026 Non-selected limits never change during a command.
REQ-027 cmd_valid while not ready is ignored; the requester holds it.
REQ-028 A new handshake may occur in the cycle after done (IDLE).

Reset
REQ-029 Reset asserted: state=IDLE, frame counter=0, all limits=CENTER, busy=0, done=0, cmd_err=0, cmd_ready=1, immediately and independent of clk.
REQ-030 Reset mid-ramp abandons the command, emits no done, and returns limits to CENTER.

Structure
REQ-031 Shared package holds the FSM state typedef, channel codes (X/Y/PEN) and default limit constants.
REQ-032 Frame counter is a sub-module, servo_frame_timer (FRAME_CYCLES parameter, output frame_tick).

Verification (FRAME_CYCLES=10, STEP=100, MIN=1000, MAX=2000, CENTER=1500)
REQ-033 Reset released -> all limits 1500, cmd_ready=1, busy=0, frame_tick every 10 cycles.
REQ-034 X target 1750 -> limit_x 1600, 1700, 1750 on three consecutive frame_ticks; done pulse one cycle after 1750; Y/pen remain 1500.
REQ-035 pen target 5 -> clamped to 1000: limit_pen 1400..1000 over 5 frames, then done.
REQ-036 Y target 1500 -> done after 2 cycles, no frame wait, busy never set; cmd_servo=3 -> cmd_err and done pulse, no limit change.
REQ-037 cmd_valid held during RAMP -> cmd_ready=0 and no acceptance until the cycle after done; then accepted.
REQ-038 Reset asserted mid-ramp at limit_x=1600 -> limit_x=1500 asynchronously, no done, FSM IDLE.

Source files
------------

// File: rtl/servo_ramp_scheduler_pkg.sv
// Shared types and constants for the servo ramp scheduler: FSM states,
// channel codes, default limits and the clamp/step arithmetic helpers.
package servo_ramp_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RAMP   = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CH_X       = 2'd0,
    CH_Y       = 2'd1,
    CH_PEN     = 2'd2,
    CH_ILLEGAL = 2'd3
  } channel_t;

  localparam int unsigned DEF_FRAME_CYCLES = 1000002;
  localparam int unsigned DEF_STEP         = 500;
  localparam int unsigned DEF_MIN_LIMIT    = 50000;
  localparam int unsigned DEF_MAX_LIMIT    = 100000;
  localparam int unsigned DEF_CENTER       = 75000;

  function automatic logic [31:0] clamp_limit(input logic [31:0] value,
                                              input logic [31:0] lo,
                                              input logic [31:0] hi);
    logic [31:0] result;
    result = value;
    if (value < lo) result = lo;
    if (value > hi) result = hi;
    return result;
  endfunction

  // Moves cur one step toward tgt, landing exactly on tgt when within reach.
  function automatic logic [31:0] step_toward(input logic [31:0] cur,
                                              input logic [31:0] tgt,
                                              input logic [31:0] step);
    logic [31:0] result;
    result = cur;
    if (tgt > cur) result = ((tgt - cur) <= step) ? tgt : cur + step;
    else if (cur > tgt) result = ((cur - tgt) <= step) ? tgt : cur - step;
    return result;
  endfunction

endpackage

// File: rtl/servo_frame_timer.sv
// Free-running frame counter; frame_tick marks the last cycle of each PWM frame.
module servo_frame_timer
  import servo_ramp_scheduler_pkg::*;
#(
  parameter int unsigned FRAME_CYCLES = DEF_FRAME_CYCLES
) (
  input  logic clk,
  input  logic reset,
  output logic frame_tick
);

  localparam int unsigned CW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;

  logic [CW-1:0] count_q;

  assign frame_tick = (count_q == CW'(FRAME_CYCLES - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           count_q <= '0;
    else if (frame_tick) count_q <= '0;
    else                 count_q <= count_q + CW'(1);
  end

endmodule

// File: rtl/servo_ramp_scheduler.sv
// Accepts one servo target at a time and ramps the selected counter_limit
// toward it by at most STEP per PWM frame, then pulses done.
module servo_ramp_scheduler
  import servo_ramp_scheduler_pkg::*;
#(
  parameter int unsigned FRAME_CYCLES = DEF_FRAME_CYCLES,
  parameter int unsigned STEP         = DEF_STEP,
  parameter int unsigned MIN_LIMIT    = DEF_MIN_LIMIT,
  parameter int unsigned MAX_LIMIT    = DEF_MAX_LIMIT,
  parameter int unsigned CENTER       = DEF_CENTER
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_servo,
  input  logic [31:0] cmd_target,
  output logic [31:0] limit_x,
  output logic [31:0] limit_y,
  output logic [31:0] limit_pen,
  output logic        busy,
  output logic        done,
  output logic        cmd_err
);

  state_t      state_q, state_d;
  channel_t    sel_q;
  logic [31:0] target_q;
  logic [31:0] limit_x_q, limit_y_q, limit_pen_q;
  logic        busy_q, done_q, err_q;
  logic        frame_tick;

  servo_frame_timer #(.FRAME_CYCLES(FRAME_CYCLES)) u_frame_timer (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick)
  );

  channel_t    cmd_ch;
  logic        handshake, illegal_hs;
  logic [31:0] cmd_clamped, cmd_cur_limit, sel_limit, stepped;

  assign cmd_ch      = channel_t'(cmd_servo);
  assign handshake   = cmd_valid && (state_q == ST_IDLE);
  assign illegal_hs  = handshake && (cmd_ch == CH_ILLEGAL);
  assign cmd_clamped = clamp_limit(cmd_target, 32'(MIN_LIMIT), 32'(MAX_LIMIT));
  assign stepped     = step_toward(sel_limit, target_q, 32'(STEP));

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    cmd_cur_limit = limit_x_q;
    sel_limit     = limit_x_q;
    case (cmd_ch)
      CH_Y:    cmd_cur_limit = limit_y_q;
      CH_PEN:  cmd_cur_limit = limit_pen_q;
      default: cmd_cur_limit = limit_x_q;
    endcase
    case (sel_q)
      CH_Y:    sel_limit = limit_y_q;
      CH_PEN:  sel_limit = limit_pen_q;
      default: sel_limit = limit_x_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:
        if (handshake && !illegal_hs)
          state_d = (cmd_clamped == cmd_cur_limit) ? ST_FINISH : ST_RAMP;
      ST_RAMP:
        if (frame_tick && (stepped == target_q)) state_d = ST_FINISH;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      sel_q    <= CH_X;
      target_q <= 32'(CENTER);
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == ST_FINISH) || illegal_hs;
      err_q   <= illegal_hs;
      if (handshake && !illegal_hs) begin
        sel_q    <= cmd_ch;
        target_q <= cmd_clamped;
      end
      // busy covers the whole ramp including its FINISH cycle, but is never
      // raised for a command that needs no movement.
      if (state_d == ST_RAMP)      busy_q <= 1'b1;
      else if (state_d == ST_IDLE) busy_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      limit_x_q   <= 32'(CENTER);
      limit_y_q   <= 32'(CENTER);
      limit_pen_q <= 32'(CENTER);
    end else if ((state_q == ST_RAMP) && frame_tick) begin
      case (sel_q)
        CH_X:    limit_x_q   <= stepped;
        CH_Y:    limit_y_q   <= stepped;
        CH_PEN:  limit_pen_q <= stepped;
        default: ;
      endcase
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = busy_q;
  assign done      = done_q;
  assign cmd_err   = err_q;
  assign limit_x   = limit_x_q;
  assign limit_y   = limit_y_q;
  assign limit_pen = limit_pen_q;

endmodule

// File: tb/tb_servo_ramp_scheduler.sv
// Self-checking bench for servo_ramp_scheduler: a behavioural frame/ramp model
// compared every cycle, directed scenarios with literal expectations, then random commands.
module tb_servo_ramp_scheduler;

  localparam int unsigned FC = 10;
  localparam int unsigned ST = 100;
  localparam int unsigned MN = 1000;
  localparam int unsigned MX = 2000;
  localparam int unsigned CT = 1500;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_servo;
  logic [31:0] cmd_target;
  logic [31:0] limit_x, limit_y, limit_pen;
  logic        busy, done, cmd_err;

  always #5 clk = ~clk;

  servo_ramp_scheduler #(
    .FRAME_CYCLES(FC), .STEP(ST), .MIN_LIMIT(MN), .MAX_LIMIT(MX), .CENTER(CT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_servo  (cmd_servo),
    .cmd_target (cmd_target),
    .limit_x    (limit_x),
    .limit_y    (limit_y),
    .limit_pen  (limit_pen),
    .busy       (busy),
    .done       (done),
    .cmd_err    (cmd_err)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: frame position from a cycle count, one pending command.
  int unsigned m_lim[3];
  int unsigned m_cnt, m_tgt;
  int          m_ch;
  bit          m_ramping, m_finish, m_busy, m_done, m_err;
  bit          chk_en = 1'b0;

  always @(posedge clk or posedge reset) begin
    bit          tick, nd, ne;
    int unsigned ct;
    if (reset) begin
      for (int i = 0; i < 3; i++) m_lim[i] = CT;
      m_cnt = 0; m_tgt = CT; m_ch = 0;
      m_ramping = 0; m_finish = 0; m_busy = 0; m_done = 0; m_err = 0;
    end else begin
      tick  = (m_cnt == FC - 1);
      m_cnt = (m_cnt + 1) % FC;
      nd = 0; ne = 0;
      if (m_finish) begin
        m_finish = 0; nd = 1; m_busy = 0;
      end else if (m_ramping) begin
        if (tick) begin
          if (m_tgt > m_lim[m_ch])
            m_lim[m_ch] = (m_tgt - m_lim[m_ch] <= ST) ? m_tgt : m_lim[m_ch] + ST;
          else
            m_lim[m_ch] = (m_lim[m_ch] - m_tgt <= ST) ? m_tgt : m_lim[m_ch] - ST;
          if (m_lim[m_ch] == m_tgt) begin
            m_ramping = 0; m_finish = 1;
          end
        end
      end else if (cmd_valid) begin
        ct = (cmd_target < MN) ? MN : (cmd_target > MX) ? MX : cmd_target;
        if (cmd_servo == 2'd3) begin
          nd = 1; ne = 1;
        end else begin
          m_ch = int'(cmd_servo); m_tgt = ct;
          if (m_lim[m_ch] == ct) m_finish = 1;
          else begin m_ramping = 1; m_busy = 1; end
        end
      end
      m_done = nd; m_err = ne;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("limit_x",   limit_x,   m_lim[0]);
      check("limit_y",   limit_y,   m_lim[1]);
      check("limit_pen", limit_pen, m_lim[2]);
      check("cmd_ready", {31'b0, cmd_ready}, {31'b0, !(m_ramping || m_finish)});
      check("busy",      {31'b0, busy},      {31'b0, m_busy});
      check("done",      {31'b0, done},      {31'b0, m_done});
      check("cmd_err",   {31'b0, cmd_err},   {31'b0, m_err});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  function automatic logic [31:0] lim_of(input int ch);
    case (ch)
      1:       return limit_y;
      2:       return limit_pen;
      default: return limit_x;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send(input logic [1:0] s, input logic [31:0] t);
    bit r;
    r = 1'b0;
    cmd_servo = s; cmd_target = t; cmd_valid = 1'b1;
    for (int n = 0; n < 300; n++) begin
      r = cmd_ready;
      @(posedge clk);
      if (r) begin
        @(negedge clk);
        cmd_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    check("send_accept", {31'b0, r}, 32'd1);
    cmd_valid = 1'b0;
  endtask

  logic [31:0] w_vals[$];
  int          w_cyc[$];
  int          w_done_at;

  task automatic watch(input int ch);
    logic [31:0] prev;
    w_vals.delete(); w_cyc.delete(); w_done_at = -1;
    prev = lim_of(ch);
    for (int k = 0; k < 200; k++) begin
      if (lim_of(ch) != prev) begin
        prev = lim_of(ch);
        w_vals.push_back(prev);
        w_cyc.push_back(k);
      end
      if (done) begin
        w_done_at = k;
        break;
      end
      @(negedge clk);
    end
    check("watch_done_seen", {31'b0, (w_done_at >= 0)}, 32'd1);
  endtask

  function automatic logic [31:0] qv(input int i);
    if (i >= 0 && i < w_vals.size()) return w_vals[i];
    return 32'hFFFF_FFFF;
  endfunction

  function automatic int qc(input int i);
    if (i >= 0 && i < w_cyc.size()) return w_cyc[i];
    return -1000;
  endfunction

  initial begin
    bit early;
    int last;
    reset = 1'b0; cmd_valid = 1'b0; cmd_servo = '0; cmd_target = '0;
    #1 reset = 1'b1;
    #1;
    check("rst_limit_x",   limit_x,   32'd1500);
    check("rst_limit_y",   limit_y,   32'd1500);
    check("rst_limit_pen", limit_pen, 32'd1500);
    check("rst_ready",     {31'b0, cmd_ready}, 32'd1);
    check("rst_busy",      {31'b0, busy},      32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    // X ramp 1500 -> 1750 in three frames.
    send(2'd0, 32'd1750);
    watch(0);
    check("x_nchanges", w_vals.size(), 32'd3);
    check("x_step0", qv(0), 32'd1600);
    check("x_step1", qv(1), 32'd1700);
    check("x_step2", qv(2), 32'd1750);
    check("x_frame_gap0", qc(1) - qc(0), 32'd10);
    check("x_frame_gap1", qc(2) - qc(1), 32'd10);
    check("x_done_lag", w_done_at - qc(2), 32'd1);
    check("x_y_untouched", limit_y, 32'd1500);
    check("x_pen_untouched", limit_pen, 32'd1500);
    @(negedge clk);

    // pen target 5 clamps to 1000.
    send(2'd2, 32'd5);
    watch(2);
    last = w_vals.size() - 1;
    check("pen_nchanges", w_vals.size(), 32'd5);
    check("pen_first", qv(0), 32'd1400);
    check("pen_last", qv(last), 32'd1000);
    check("pen_done_lag", w_done_at - qc(last), 32'd1);
    @(negedge clk);

    // Y already at target: done two cycles after the handshake edge, never busy.
    send(2'd1, 32'd1500);
    check("yeq_done_early", {31'b0, done}, 32'd0);
    check("yeq_busy0", {31'b0, busy}, 32'd0);
    @(negedge clk);
    check("yeq_done", {31'b0, done}, 32'd1);
    check("yeq_busy1", {31'b0, busy}, 32'd0);
    check("yeq_err", {31'b0, cmd_err}, 32'd0);

    // Illegal channel.
    send(2'd3, 32'd1234);
    check("ill_err", {31'b0, cmd_err}, 32'd1);
    check("ill_done", {31'b0, done}, 32'd1);
    check("ill_ready", {31'b0, cmd_ready}, 32'd1);
    check("ill_x", limit_x, 32'd1750);
    @(negedge clk);
    check("ill_err_pulse", {31'b0, cmd_err}, 32'd0);

    // Command held during a ramp is accepted only after done.
    send(2'd0, 32'd1200);
    cmd_servo = 2'd1; cmd_target = 32'd1800; cmd_valid = 1'b1;
    early = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (done) break;
      if (cmd_ready) early = 1'b1;
      @(negedge clk);
    end
    check("hold_no_early_ready", {31'b0, early}, 32'd0);
    check("hold_x_final", limit_x, 32'd1200);
    check("hold_done", {31'b0, done}, 32'd1);
    check("hold_ready_at_done", {31'b0, cmd_ready}, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("hold_accepted_busy", {31'b0, busy}, 32'd1);
    check("hold_accepted_ready", {31'b0, cmd_ready}, 32'd0);
    watch(1);
    check("hold_y_final", limit_y, 32'd1800);
    @(negedge clk);

    // Reset in the middle of a ramp at limit_x = 1600.
    send(2'd0, 32'd1800);
    for (int k = 0; k < 200; k++) begin
      if (limit_x == 32'd1600) break;
      @(negedge clk);
    end
    check("mid_reached_1600", limit_x, 32'd1600);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_x", limit_x, 32'd1500);
    check("mid_rst_y", limit_y, 32'd1500);
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    check("mid_rst_ready", {31'b0, cmd_ready}, 32'd1);
    check("mid_rst_done", {31'b0, done}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Random commands, sometimes issued back-to-back while a ramp is running.
    for (int n = 0; n < 70; n++) begin
      int          sel, mode;
      logic [1:0]  s;
      logic [31:0] t;
      sel = $urandom_range(0, 9);
      s = (sel == 9) ? 2'd3 : 2'(sel % 3);
      mode = $urandom_range(0, 4);
      case (mode)
        0: t = $urandom_range(800, 2200);
        1: t = lim_of(int'(s)) + $urandom_range(0, 350) - 175;
        2: t = lim_of(int'(s));
        3: begin
          case ($urandom_range(0, 3))
            0:       t = 32'd0;
            1:       t = 32'hFFFF_FFFF;
            2:       t = MN;
            default: t = MX;
          endcase
        end
        default: t = $urandom();
      endcase
      send(s, t);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if ($urandom_range(0, 29) == 0) begin
        #3 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
      end
    end
    for (int k = 0; k < 300; k++) begin
      if (cmd_ready && !busy && !done) break;
      @(negedge clk);
    end
    check("final_idle", {31'b0, cmd_ready}, 32'd1);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
